// File: rtl/codificador_pkg.sv
// Shared types and defaults for the sequential 8-to-3 encoder.
package codificador_pkg;

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} estado_t;

   localparam int N_DEF = 8;

endpackage

// File: rtl/codificador_prio_comb.sv
// Combinational priority encoder: index of the highest set bit of vec.
module codificador_prio_comb #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] index,
   output logic         any
);

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      index = '0;
      any   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            index = W'(i);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/codificador_sequencial.sv
// Sequential encoder: snapshots request lines and emits each set index,
// highest first, over a valid/ready handshake, then pulses done.
module codificador_sequencial
   import codificador_pkg::*;
#(
   parameter int N = N_DEF,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] e,
   input  logic         load,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] b,
   output logic         busy,
   output logic [W:0]   pendentes,
   output logic         done
);

   estado_t      estado_q, estado_d;
   logic [N-1:0] pend_q, pend_d;
   logic         done_q, done_d;

   logic [W-1:0] top_index;
   logic         top_any;
   logic [N-1:0] clr_mask;
   logic [N-1:0] pend_cleared;

   codificador_prio_comb #(.N(N)) u_prio (
      .vec   (pend_q),
      .index (top_index),
      .any   (top_any)
   );

   assign clr_mask     = N'(1) << top_index;
   assign pend_cleared = pend_q & ~clr_mask;

   always_comb begin
      estado_d = estado_q;
      pend_d   = pend_q;
      done_d   = 1'b0;
      case (estado_q)
         IDLE: begin
            // ready is irrelevant here; only load moves the machine.
            if (load) begin
               pend_d = e;
               if (e == '0) begin
                  done_d = 1'b1;
               end else begin
                  estado_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (ready && top_any) begin
               pend_d = pend_cleared;
               if (pend_cleared == '0) begin
                  estado_d = IDLE;
                  done_d   = 1'b1;
               end
            end
         end
         default: begin
            estado_d = IDLE;
            pend_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= IDLE;
         pend_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      pendentes = '0;
      for (int i = 0; i < N; i++) begin
         pendentes = pendentes + (W+1)'(pend_q[i]);
      end
   end

   assign valid = (estado_q == EMIT);
   assign busy  = (estado_q == EMIT);
   assign b     = valid ? top_index : '0;
   assign done  = done_q;

endmodule

// File: tb/tb_codificador_sequencial.sv
// Self-checking bench for codificador_sequencial: vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_codificador_sequencial;

   logic       clk;
   logic       rst;
   logic [7:0] e;
   logic       load;
   logic       ready;
   logic       valid;
   logic [2:0] b;
   logic       busy;
   logic [3:0] pendentes;
   logic       done;

   int tests  = 0;
   int failed = 0;

   codificador_sequencial #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .e         (e),
      .load      (load),
      .ready     (ready),
      .valid     (valid),
      .b         (b),
      .busy      (busy),
      .pendentes (pendentes),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  e;
      int          k;
      logic [23:0] idx;   // expected index j in octal digit j (j=0 emitted first)
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model-side decoder: index -> one-hot line.
   function automatic logic [7:0] decode(input logic [2:0] idx);
      logic [7:0] one;
      one = 8'd1;
      return one << idx;
   endfunction

   function automatic logic [7:0] highest(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) if (v[i]) return decode(3'(i));
      return 8'd0;
   endfunction

   task automatic run_snapshot(input logic [7:0] ev, input int k, input logic [23:0] idx);
      logic [23:0] d;
      load = 1'b1; e = ev; ready = 1'b1;
      step();
      load = 1'b0;
      d = idx;
      for (int j = 0; j < k; j++) begin
         chk("tbl_valid", int'(valid), 1);
         chk("tbl_b", int'(b), int'(d[2:0]));
         chk("tbl_pend", int'(pendentes), k - j);
         chk("tbl_done_low", int'(done), 0);
         d = d >> 3;
         step();
      end
      chk("tbl_end_valid", int'(valid), 0);
      chk("tbl_end_busy", int'(busy), 0);
      chk("tbl_done", int'(done), 1);
      $display("[TB] table e=%02h k=%0d emitted", ev, k);
      ready = 1'b0;
      step();
      chk("tbl_done_pulse", int'(done), 0);
   endtask

   initial begin
      logic [7:0] rem;
      logic [7:0] ev;
      logic [2:0] q[$];
      logic [2:0] b_prev;
      int         r;
      int         cyc;

      tbl[0] = '{8'hA4, 3, 24'o257};
      tbl[1] = '{8'h00, 0, 24'o0};
      tbl[2] = '{8'h01, 1, 24'o0};
      tbl[3] = '{8'hFF, 8, 24'o01234567};
      tbl[4] = '{8'h81, 2, 24'o07};
      tbl[5] = '{8'h10, 1, 24'o4};

      // Reset state
      rst = 1'b1; e = '0; load = 1'b0; ready = 1'b0;
      #12;
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      @(negedge clk) rst = 1'b0;
      step();
      chk("rel_valid", int'(valid), 0);
      chk("rel_b", int'(b), 0);
      chk("rel_pend", int'(pendentes), 0);
      $display("[TB] reset checked");

      for (int i = 0; i < 6; i++) run_snapshot(tbl[i].e, tbl[i].k, tbl[i].idx);

      // ready held low: index must stay put
      load = 1'b1; e = 8'h81; ready = 1'b0;
      step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", int'(valid), 1);
         chk("hold_b", int'(b), 7);
         chk("hold_pend", int'(pendentes), 2);
         step();
      end
      ready = 1'b1;
      chk("hold_b_last", int'(b), 7);
      step();
      chk("hold_b0", int'(b), 0);
      chk("hold_b0_valid", int'(valid), 1);
      step();
      chk("hold_done", int'(done), 1);
      $display("[TB] ready-stall sequence done");
      ready = 1'b0;
      step();

      // load during EMIT is ignored
      load = 1'b1; e = 8'h24; ready = 1'b0;
      step();
      load = 1'b1; e = 8'hFF; ready = 1'b1;
      step();
      load = 1'b0;
      chk("ign_b", int'(b), 2);
      chk("ign_pend", int'(pendentes), 1);
      step();
      chk("ign_done", int'(done), 1);
      chk("ign_valid", int'(valid), 0);
      ready = 1'b0;
      step();
      chk("ign_idle_pend", int'(pendentes), 0);
      $display("[TB] load-in-EMIT sequence done");

      // async reset mid-EMIT
      load = 1'b1; e = 8'hF0; ready = 1'b0;
      step();
      load = 1'b0; ready = 1'b1;
      step();
      ready = 1'b0;
      chk("mid_pend", int'(pendentes), 3);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", int'(valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_pend", int'(pendentes), 0);
      @(negedge clk) rst = 1'b0;
      step();
      chk("mid_no_done", int'(done), 0);
      step();
      chk("mid_no_done2", int'(done), 0);
      $display("[TB] mid-EMIT reset done");
      run_snapshot(8'h0C, 2, 24'o23);

      // randomized run against queue model
      for (int t = 0; t < 40; t++) begin
         ev = 8'($urandom);
         if (t % 8 == 0) ev = 8'h00;
         load = 1'b1; e = ev; ready = 1'($urandom);
         step();
         load = 1'b0;
         q.delete();
         for (int i = 7; i >= 0; i--) if (ev[i]) q.push_back(3'(i));
         rem = ev;
         cyc = 0;
         while (q.size() > 0 && cyc < 200) begin
            chk("rnd_valid", int'(valid), 1);
            chk("rnd_b", int'(b), int'(q[0]));
            chk("rnd_pend", int'(pendentes), q.size());
            chk("rnd_done_low", int'(done), 0);
            b_prev = b;
            r = int'($urandom_range(0, 1));
            ready = r[0]; load = 1'($urandom); e = 8'($urandom);
            step();
            cyc++;
            if (r != 0) begin
               chk("rnd_decode", int'(decode(b_prev)), int'(highest(rem)));
               rem = rem & ~decode(b_prev);
               void'(q.pop_front());
            end
         end
         if (cyc >= 200) chk("rnd_timeout", cyc, 0);
         load = 1'b0; ready = 1'b0;
         chk("rnd_end_valid", int'(valid), 0);
         chk("rnd_done", int'(done), 1);
         $display("[TB] random e=%02h emitted in %0d cycles", ev, cyc);
         step();
         chk("rnd_done_pulse", int'(done), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
